// File: rtl/object_motion_ctrl.sv
// Frame-synchronous position controller for one square_object: moves the top-left corner
// by a signed velocity once per frame and reflects off screen bounds and latched collisions.
module object_motion_ctrl #(
    parameter int OBJECT_WIDTH_X  = 16,
    parameter int OBJECT_HEIGHT_Y = 32,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 640,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               enable,
    input  logic               startOfFrame,
    input  logic               hit_x,
    input  logic               hit_y,
    input  logic signed [10:0] init_x,
    input  logic signed [10:0] init_y,
    input  logic signed [7:0]  speed_x,
    input  logic signed [7:0]  speed_y,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               moving,
    output logic               pos_valid,
    output logic               bounce
);

    localparam logic signed [11:0] X_LO = 12'(X_MIN);
    localparam logic signed [11:0] X_HI = 12'(X_MAX - OBJECT_WIDTH_X);
    localparam logic signed [11:0] Y_LO = 12'(Y_MIN);
    localparam logic signed [11:0] Y_HI = 12'(Y_MAX - OBJECT_HEIGHT_Y);

    typedef enum logic [1:0] {IDLE, RUN, UPDATE, DONE} state_t;

    typedef struct packed {
        logic signed [10:0] pos;
        logic signed [7:0]  vel;
        logic               flip;
    } axis_t;

    state_t             state;
    logic signed [7:0]  vel_x;
    logic signed [7:0]  vel_y;
    logic               latch_x;
    logic               latch_y;
    logic               flip_seen;
    axis_t              next_x;
    axis_t              next_y;

    // -128 has no positive twin in 8 bits, so reversal saturates to +127.
    function automatic logic signed [7:0] sat_neg(input logic signed [7:0] v);
        if (v == 8'sb1000_0000) begin
            return 8'sd127;
        end
        return -v;
    endfunction

    function automatic axis_t step_axis(input logic signed [10:0] pos,
                                        input logic signed [7:0]  vel,
                                        input logic               hit,
                                        input logic signed [11:0] lo,
                                        input logic signed [11:0] hi);
        axis_t             r;
        logic signed [11:0] n;
        n      = $signed({pos[10], pos}) + $signed({{4{vel[7]}}, vel});
        r.pos  = pos;
        r.vel  = vel;
        r.flip = 1'b0;
        if (hit) begin
            r.vel  = sat_neg(vel);
            r.flip = 1'b1;
        end else if (n < lo) begin
            r.pos  = lo[10:0];
            r.vel  = sat_neg(vel);
            r.flip = 1'b1;
        end else if (n > hi) begin
            r.pos  = hi[10:0];
            r.vel  = sat_neg(vel);
            r.flip = 1'b1;
        end else begin
            r.pos  = n[10:0];
        end
        return r;
    endfunction

    // A hit arriving in the same cycle as startOfFrame still counts for this frame.
    always_comb begin
        next_x = step_axis(topLeftX, vel_x, latch_x | hit_x, X_LO, X_HI);
        next_y = step_axis(topLeftY, vel_y, latch_y | hit_y, Y_LO, Y_HI);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            topLeftX  <= X_LO[10:0];
            topLeftY  <= Y_LO[10:0];
            vel_x     <= '0;
            vel_y     <= '0;
            latch_x   <= 1'b0;
            latch_y   <= 1'b0;
            flip_seen <= 1'b0;
            moving    <= 1'b0;
            pos_valid <= 1'b0;
            bounce    <= 1'b0;
        end else begin
            pos_valid <= 1'b0;
            bounce    <= 1'b0;
            if (start) begin
                topLeftX <= init_x;
                topLeftY <= init_y;
                vel_x    <= speed_x;
                vel_y    <= speed_y;
                latch_x  <= 1'b0;
                latch_y  <= 1'b0;
                state    <= RUN;
                moving   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        moving <= 1'b0;
                    end
                    RUN: begin
                        if (startOfFrame && enable) begin
                            // Position is committed on entry to UPDATE so it is visible one cycle after the frame pulse.
                            topLeftX  <= next_x.pos;
                            topLeftY  <= next_y.pos;
                            vel_x     <= next_x.vel;
                            vel_y     <= next_y.vel;
                            flip_seen <= next_x.flip | next_y.flip;
                            latch_x   <= 1'b0;
                            latch_y   <= 1'b0;
                            state     <= UPDATE;
                        end else begin
                            latch_x <= latch_x | hit_x;
                            latch_y <= latch_y | hit_y;
                        end
                        moving <= 1'b1;
                    end
                    UPDATE: begin
                        latch_x   <= latch_x | hit_x;
                        latch_y   <= latch_y | hit_y;
                        pos_valid <= 1'b1;
                        bounce    <= flip_seen;
                        state     <= DONE;
                        moving    <= 1'b0;
                    end
                    DONE: begin
                        latch_x <= latch_x | hit_x;
                        latch_y <= latch_y | hit_y;
                        state   <= RUN;
                        moving  <= 1'b1;
                    end
                    default: begin
                        state  <= IDLE;
                        moving <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_object_motion_ctrl.sv
// Randomized self-checking bench for object_motion_ctrl with a frame-level reference model.
module tb_object_motion_ctrl;

    logic               clk = 1'b0;
    logic               rst, start, enable, sof, hit_x, hit_y;
    logic signed [10:0] init_x, init_y;
    logic signed [7:0]  speed_x, speed_y;
    logic signed [10:0] top_x, top_y;
    logic               moving, pos_valid, bounce;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_x, m_y, m_vx, m_vy, m_bounce;
    bit m_lx, m_ly;

    localparam int XLIM = 640 - 16;
    localparam int YLIM = 480 - 32;

    always #5 clk = ~clk;

    object_motion_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .startOfFrame(sof),
        .hit_x(hit_x), .hit_y(hit_y), .init_x(init_x), .init_y(init_y),
        .speed_x(speed_x), .speed_y(speed_y), .topLeftX(top_x), .topLeftY(top_y),
        .moving(moving), .pos_valid(pos_valid), .bounce(bounce)
    );

    function automatic int neg8(input int v);
        return (v == -128) ? 127 : -v;
    endfunction

    function automatic void model_axis(inout int p, inout int v, input bit hit,
                                       input int lo, input int hi, inout int b);
        int n;
        n = p + v;
        if (hit) begin v = neg8(v); b = 1; end
        else if (n < lo) begin p = lo; v = neg8(v); b = 1; end
        else if (n > hi) begin p = hi; v = neg8(v); b = 1; end
        else p = n;
    endfunction

    task automatic model_update();
        int b;
        b = 0;
        model_axis(m_x, m_vx, m_lx, 0, XLIM, b);
        model_axis(m_y, m_vy, m_ly, 0, YLIM, b);
        m_lx = 0;
        m_ly = 0;
        m_bounce = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int ix, input int iy, input int sx, input int sy);
        init_x  = 11'(ix);
        init_y  = 11'(iy);
        speed_x = 8'(sx);
        speed_y = 8'(sy);
        start   = 1'b1;
        tick();
        start = 1'b0;
        m_x = ix; m_y = iy; m_vx = sx; m_vy = sy; m_lx = 0; m_ly = 0;
    endtask

    task automatic pulse_hit(input bit hx, input bit hy);
        hit_x = hx;
        hit_y = hy;
        tick();
        hit_x = 1'b0;
        hit_y = 1'b0;
        m_lx |= hx;
        m_ly |= hy;
    endtask

    // Frame pulse, then the cycle after it (hits optionally driven), then DONE, then back in RUN.
    task automatic run_frame(input bit en, input bit hxu, input bit hyu,
                             output int ox, output int oy, output logic opv,
                             output logic obnc, output logic opv2, output logic omov);
        enable = en;
        sof    = 1'b1;
        tick();
        sof   = 1'b0;
        hit_x = hxu;
        hit_y = hyu;
        if (en) model_update();
        else m_bounce = 0;
        ox = int'(top_x);
        oy = int'(top_y);
        m_lx |= hxu;
        m_ly |= hyu;
        tick();
        hit_x = 1'b0;
        hit_y = 1'b0;
        opv   = pos_valid;
        obnc  = bounce;
        tick();
        opv2   = pos_valid;
        omov   = moving;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; enable = 1'b1; sof = 1'b0; hit_x = 1'b0; hit_y = 1'b0;
        init_x = 11'sd300; init_y = 11'sd300; speed_x = 8'sd5; speed_y = 8'sd5;
        repeat (3) tick();
        checks++; if (top_x !== 11'sd0 || top_y !== 11'sd0) begin errors++;
            $display("FAIL reset_pos got (%0d,%0d) exp (0,0)", top_x, top_y); end
        checks++; if ({moving, pos_valid, bounce} !== 3'b000) begin errors++;
            $display("FAIL reset_flags got %b exp 000", {moving, pos_valid, bounce}); end
        rst = 1'b0;
        tick();
        sof = 1'b1; tick(); sof = 1'b0; tick();
        checks++; if (top_x !== 11'sd0 || pos_valid !== 1'b0 || moving !== 1'b0) begin errors++;
            $display("FAIL idle_hold got x=%0d pv=%b mv=%b exp 0,0,0", top_x, pos_valid, moving); end
    endtask

    task automatic test_basic();
        int ox, oy; logic pv, bn, pv2, mv;
        do_start(100, 50, 3, -2);
        for (int f = 0; f < 3; f++) begin
            repeat (2) tick();
            run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
            checks++; if (ox !== 103 + 3*f || oy !== 48 - 2*f) begin errors++;
                $display("FAIL basic_pos f=%0d got (%0d,%0d) exp (%0d,%0d)", f, ox, oy, 103+3*f, 48-2*f); end
            checks++; if (pv !== 1'b1 || bn !== 1'b0 || pv2 !== 1'b0 || mv !== 1'b1) begin errors++;
                $display("FAIL basic_flags f=%0d got pv=%b bn=%b pv2=%b mv=%b exp 1,0,0,1", f, pv, bn, pv2, mv); end
        end
    endtask

    task automatic test_edges();
        int ox, oy; logic pv, bn, pv2, mv;
        do_start(622, 0, 5, 0);
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (ox !== 624 || bn !== 1'b1) begin errors++;
            $display("FAIL right_edge got x=%0d bn=%b exp 624,1", ox, bn); end
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (ox !== 619 || bn !== 1'b0) begin errors++;
            $display("FAIL right_return got x=%0d bn=%b exp 619,0", ox, bn); end
        do_start(0, 1, 0, -4);
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (oy !== 0 || bn !== 1'b1) begin errors++;
            $display("FAIL top_edge got y=%0d bn=%b exp 0,1", oy, bn); end
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (oy !== 4) begin errors++;
            $display("FAIL top_return got y=%0d exp 4", oy); end
    endtask

    task automatic test_hits();
        int ox, oy; logic pv, bn, pv2, mv;
        do_start(200, 100, 2, 0);
        repeat (3) tick();
        pulse_hit(1'b1, 1'b0);
        repeat (2) tick();
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (ox !== 200 || bn !== 1'b1) begin errors++;
            $display("FAIL hit_x got x=%0d bn=%b exp 200,1", ox, bn); end
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (ox !== 198 || bn !== 1'b0) begin errors++;
            $display("FAIL hit_x_next got x=%0d bn=%b exp 198,0", ox, bn); end
        // hit during the update cycle belongs to the following frame
        do_start(200, 100, 2, 0);
        run_frame(1'b1, 1'b1, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (ox !== 202 || bn !== 1'b0) begin errors++;
            $display("FAIL hit_upd_now got x=%0d bn=%b exp 202,0", ox, bn); end
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (ox !== 202 || bn !== 1'b1) begin errors++;
            $display("FAIL hit_upd_next got x=%0d bn=%b exp 202,1", ox, bn); end
    endtask

    task automatic test_pause();
        int ox, oy; logic pv, bn, pv2, mv;
        do_start(100, 100, 4, 4);
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        for (int k = 0; k < 2; k++) begin
            run_frame(1'b0, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
            checks++; if (ox !== 104 || oy !== 104 || pv !== 1'b0) begin errors++;
                $display("FAIL pause k=%0d got (%0d,%0d) pv=%b exp (104,104) 0", k, ox, oy, pv); end
        end
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (ox !== 108 || oy !== 108 || pv !== 1'b1) begin errors++;
            $display("FAIL resume got (%0d,%0d) pv=%b exp (108,108) 1", ox, oy, pv); end
    endtask

    task automatic test_limits();
        int ox, oy; logic pv, bn, pv2, mv;
        do_start(50, 300, -128, 0);
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (ox !== 0 || oy !== 300 || bn !== 1'b1) begin errors++;
            $display("FAIL sat_clamp got (%0d,%0d) bn=%b exp (0,300) 1", ox, oy, bn); end
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (ox !== 127) begin errors++;
            $display("FAIL sat_neg got x=%0d exp 127", ox); end
        do_start(700, -20, 0, 0);
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (ox !== 624 || oy !== 0) begin errors++;
            $display("FAIL init_clamp got (%0d,%0d) exp (624,0)", ox, oy); end
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (ox !== 624 || oy !== 0 || pv !== 1'b1 || bn !== 1'b0) begin errors++;
            $display("FAIL zero_speed got (%0d,%0d) pv=%b bn=%b exp (624,0) 1 0", ox, oy, pv, bn); end
    endtask

    task automatic test_sof_hold();
        do_start(10, 10, 1, 1);
        sof = 1'b1;
        tick();
        model_update();
        tick();
        sof = 1'b0;
        checks++; if (top_x !== 11'sd11 || pos_valid !== 1'b1) begin errors++;
            $display("FAIL sof_hold_done got x=%0d pv=%b exp 11,1", top_x, pos_valid); end
        tick();
        tick();
        checks++; if (top_x !== 11'sd11 || top_y !== 11'sd11 || pos_valid !== 1'b0) begin errors++;
            $display("FAIL sof_hold_once got (%0d,%0d) pv=%b exp (11,11) 0", top_x, top_y, pos_valid); end
    endtask

    task automatic test_restart();
        int ox, oy; logic pv, bn, pv2, mv;
        do_start(300, 300, 7, 7);
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        pulse_hit(1'b1, 1'b1);
        do_start(50, 60, -1, 1);
        run_frame(1'b1, 1'b0, 1'b0, ox, oy, pv, bn, pv2, mv);
        checks++; if (ox !== 49 || oy !== 61 || bn !== 1'b0) begin errors++;
            $display("FAIL restart got (%0d,%0d) bn=%b exp (49,61) 0", ox, oy, bn); end
    endtask

    task automatic test_reset_in_update();
        do_start(300, 200, 5, 5);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (top_x !== 11'sd0 || top_y !== 11'sd0 || moving !== 1'b0) begin errors++;
            $display("FAIL async_reset got (%0d,%0d) mv=%b exp (0,0) 0", top_x, top_y, moving); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int ox, oy; logic pv, bn, pv2, mv;
        bit en, hxu, hyu;
        for (int i = 0; i < 60; i++) begin
            if (i % 15 == 0)
                do_start(int'($urandom_range(0, 850)) - 100, int'($urandom_range(0, 650)) - 100,
                         int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            repeat ($urandom_range(0, 4))
                pulse_hit($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            en  = ($urandom_range(0, 3) != 0);
            hxu = ($urandom_range(0, 7) == 0);
            hyu = ($urandom_range(0, 7) == 0);
            run_frame(en, hxu, hyu, ox, oy, pv, bn, pv2, mv);
            checks++; if (ox !== m_x || oy !== m_y) begin errors++;
                $display("FAIL rand_pos i=%0d got (%0d,%0d) exp (%0d,%0d)", i, ox, oy, m_x, m_y); end
            checks++; if (pv !== en || bn !== (m_bounce != 0) || pv2 !== 1'b0) begin errors++;
                $display("FAIL rand_flags i=%0d got pv=%b bn=%b pv2=%b exp %b %b 0", i, pv, bn, pv2, en, m_bounce != 0); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_hits();
        test_pause();
        test_limits();
        test_sof_hold();
        test_restart();
        test_reset_in_update();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
